// File: rtl/cla_ctrl_pkg.sv
// Shared types and constants for the serial carry-lookahead adder controller.
package cla_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla_slice_4bit.sv
// Combinational 4-bit carry-lookahead slice with group propagate/generate.
module cla_slice_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       p,
  output logic       g
);

  logic [3:0] pi;
  logic [3:0] gi;
  logic [3:0] c;

  assign pi = a ^ b;
  assign gi = a & b;

  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & cin);

  assign s = pi ^ c;
  assign p = &pi;
  assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
           | (pi[3] & pi[2] & pi[1] & gi[0]);

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder built around one shared 4-bit CLA slice.
// Optional signed-overflow output enabled by defining CLA_SERIAL_OVF_EN.
//
// state | meaning
// IDLE  | waiting for operands, start_ready high
// ADD   | one nibble per cycle, LSB first, carry chained through carry_reg
// DONE  | result held on sum/c_out until res_ready
module cla_serial_add_ctrl
  import cla_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
`ifdef CLA_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NIBBLES = nib_count(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             nib_p;
  logic             nib_g;
  logic             carry_nxt;
  logic             accept;
  logic             last_nib;

  assign nib_a     = a_reg[{idx, 2'b00} +: NIBBLE_W];
  assign nib_b     = b_reg[{idx, 2'b00} +: NIBBLE_W];
  assign carry_nxt = nib_g | (nib_p & carry_reg);
  assign accept    = start_valid && start_ready;
  assign last_nib  = (idx == LAST_IDX);

  cla_slice_4bit u_slice (
    .a   (nib_a),
    .b   (nib_b),
    .cin (carry_reg),
    .s   (nib_s),
    .p   (nib_p),
    .g   (nib_g)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = ADD;
      ADD:     if (last_nib)    state_nxt = DONE;
      DONE:    if (res_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE:    start_ready = 1'b1;
      ADD:     busy        = 1'b1;
      DONE: begin
        res_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand registers decouple the result from input changes after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (accept) begin
      a_reg     <= in1;
      b_reg     <= in2;
      carry_reg <= c_in;
      idx       <= '0;
      sum       <= '0;
    end else if (state == ADD) begin
      sum[{idx, 2'b00} +: NIBBLE_W] <= nib_s;
      carry_reg <= carry_nxt;
      if (last_nib) begin
        c_out <= carry_nxt;
`ifdef CLA_SERIAL_OVF_EN
        ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (nib_s[3] != a_reg[WIDTH-1]);
`endif
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule
